l4_route_seq: RTL and testbench

- Sequences one wavefront-expansion search on the 32x32, 8-layer L4 router cell array.
- Drives the array's broadcast command, preference strobes and row/column selects; samples the array's registered, wire-ANDed, active-low status bus.
- Detects target reached, blocked, or step timeout.
- On failure or abort, issues a layer-wide CLEARX sweep. On success it leaves expansion markers in place for host traceback.

---
 rtl/l4_route_seq.sv | 215 +++++++++++++++++++++
 tb/tb_l4_route_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/l4_route_seq.sv
// Wavefront-expansion search sequencer for the 32x32, 8-layer L4 router cell array.
// Steps the array through EXPAND/READ/CLEARX and classifies the search as found, blocked or timed out.
module l4_route_seq #(
    parameter int unsigned NLAYERS   = 8,
    parameter int unsigned ROWS      = 32,
    parameter int unsigned COLS      = 32,
    parameter int unsigned MAX_STEPS = 1023
) (
    input  logic            clk,
    input  logic            reset_l,
    input  logic            start,
    input  logic            abort,
    input  logic [4:0]      tgt_row,
    input  logic [4:0]      tgt_col,
    input  logic            allow_etch,
    input  logic            ext_mode,
    input  logic [3:0]      status,
    output logic [1:0]      cmd,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_sel,
    output logic            pref_ud,
    output logic            pref_ew,
    output logic            pref_ns,
    output logic            etch_enb,
    output logic            extend,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic            fail,
    output logic [9:0]      step_count
);

    // Array command encoding, matching the L4_decs.v definitions.
    localparam logic [1:0] CmdClearx = 2'd0;
    localparam logic [1:0] CmdWrite  = 2'd1;
    localparam logic [1:0] CmdExpand = 2'd2;
    localparam logic [1:0] CmdRead   = 2'd3;

    localparam int unsigned PW        = (NLAYERS > 1) ? $clog2(NLAYERS) : 1;
    localparam logic [PW-1:0] LastPhase = PW'(NLAYERS - 1);
    localparam logic [9:0]    MaxSteps  = 10'(MAX_STEPS);

    typedef enum logic [2:0] {StIdle, StExpand, StDrain, StClear, StDone} state_e;

    state_e        state_q;
    logic [PW-1:0] phase_q;
    logic [4:0]    tgt_row_q;
    logic [4:0]    tgt_col_q;
    logic          etch_q;
    logic          ext_q;
    logic          prog_q;
    logic          hit_q;

    logic          prog_now;
    logic          hit_now;
    logic [9:0]    step_inc;

    // Status bus is active-low; the current sample is folded in before the step-end decision.
    assign prog_now = prog_q | ~status[1];
    assign hit_now  = hit_q | ~status[0];
    assign step_inc = (step_count == 10'h3FF) ? step_count : step_count + 10'd1;

    function automatic logic [ROWS-1:0] row_dec(input logic [4:0] idx);
        row_dec = '0;
        for (int i = 0; i < ROWS; i++) begin
            if ({27'd0, idx} == 32'(i)) row_dec[i] = 1'b1;
        end
    endfunction

    function automatic logic [COLS-1:0] col_dec(input logic [4:0] idx);
        col_dec = '0;
        for (int i = 0; i < COLS; i++) begin
            if ({27'd0, idx} == 32'(i)) col_dec[i] = 1'b1;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            tgt_row_q  <= '0;
            tgt_col_q  <= '0;
            etch_q     <= 1'b0;
            ext_q      <= 1'b0;
            prog_q     <= 1'b0;
            hit_q      <= 1'b0;
            cmd        <= CmdRead;
            row_sel    <= '0;
            col_sel    <= '0;
            pref_ud    <= 1'b0;
            pref_ew    <= 1'b0;
            pref_ns    <= 1'b0;
            etch_enb   <= 1'b0;
            extend     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            fail       <= 1'b0;
            step_count <= '0;
        end else begin
            // Outputs are registered for the state being entered; idle values unless overridden.
            done     <= 1'b0;
            cmd      <= CmdRead;
            row_sel  <= '0;
            col_sel  <= '0;
            pref_ud  <= 1'b0;
            pref_ew  <= 1'b0;
            pref_ns  <= 1'b0;
            etch_enb <= 1'b0;
            extend   <= 1'b0;

            if (abort && (state_q == StExpand || state_q == StDrain)) begin
                state_q <= StClear;
                phase_q <= '0;
                cmd     <= CmdClearx;
                pref_ud <= 1'b1;
                extend  <= ext_q;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            tgt_row_q  <= tgt_row;
                            tgt_col_q  <= tgt_col;
                            etch_q     <= allow_etch;
                            ext_q      <= ext_mode;
                            found      <= 1'b0;
                            fail       <= 1'b0;
                            step_count <= '0;
                            busy       <= 1'b1;
                            prog_q     <= 1'b0;
                            hit_q      <= 1'b0;
                            phase_q    <= '0;
                            state_q    <= StExpand;
                            cmd        <= CmdExpand;
                            pref_ud    <= 1'b1;
                            pref_ew    <= 1'b1;
                            pref_ns    <= 1'b1;
                            row_sel    <= row_dec(tgt_row);
                            col_sel    <= col_dec(tgt_col);
                            etch_enb   <= allow_etch;
                            extend     <= ext_mode;
                        end
                    end
                    StExpand: begin
                        // Phase 0 still sees the status of the preceding READ cycle.
                        if (phase_q != '0) begin
                            prog_q <= prog_now;
                            hit_q  <= hit_now;
                        end
                        if (phase_q == LastPhase) begin
                            state_q <= StDrain;
                        end else begin
                            phase_q  <= phase_q + PW'(1);
                            cmd      <= CmdExpand;
                            pref_ud  <= 1'b1;
                            pref_ew  <= 1'b1;
                            pref_ns  <= 1'b1;
                            row_sel  <= row_dec(tgt_row_q);
                            col_sel  <= col_dec(tgt_col_q);
                            etch_enb <= etch_q;
                            extend   <= ext_q;
                        end
                    end
                    StDrain: begin
                        step_count <= step_inc;
                        phase_q    <= '0;
                        if (hit_now) begin
                            found   <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else if (!prog_now || step_inc == MaxSteps) begin
                            fail    <= 1'b1;
                            state_q <= StClear;
                            cmd     <= CmdClearx;
                            pref_ud <= 1'b1;
                            extend  <= ext_q;
                        end else begin
                            prog_q   <= 1'b0;
                            hit_q    <= 1'b0;
                            state_q  <= StExpand;
                            cmd      <= CmdExpand;
                            pref_ud  <= 1'b1;
                            pref_ew  <= 1'b1;
                            pref_ns  <= 1'b1;
                            row_sel  <= row_dec(tgt_row_q);
                            col_sel  <= col_dec(tgt_col_q);
                            etch_enb <= etch_q;
                            extend   <= ext_q;
                        end
                    end
                    StClear: begin
                        if (phase_q == LastPhase) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                            cmd     <= CmdClearx;
                            pref_ud <= 1'b1;
                            extend  <= ext_q;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_l4_route_seq.sv
// Directed bench for l4_route_seq with a small registered model of the array status bus.
module tb_l4_route_seq;

    localparam logic [1:0] CmdClearx = 2'd0;
    localparam logic [1:0] CmdExpand = 2'd2;
    localparam logic [1:0] CmdRead   = 2'd3;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  tgt_row = '0;
    logic [4:0]  tgt_col = '0;
    logic        allow_etch = 1'b0;
    logic        ext_mode = 1'b0;
    logic [3:0]  status = 4'hF;
    logic [1:0]  cmd;
    logic [31:0] row_sel;
    logic [31:0] col_sel;
    logic        pref_ud, pref_ew, pref_ns, etch_enb, extend;
    logic        busy, done, found, fail;
    logic [9:0]  step_count;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int exp_cnt = 0;
    int clearx_total = 0;
    int clr_bad = 0;
    int sel_bad = 0;
    int hit_step = 0;
    logic prog_en = 1'b1;
    logic [31:0] exp_row = '0;
    logic [31:0] exp_col = '0;
    int base_clr, base_clr_bad, base_sel;

    always #5 clk = ~clk;

    l4_route_seq #(.MAX_STEPS(4)) dut (
        .clk(clk), .reset_l(reset_l), .start(start), .abort(abort),
        .tgt_row(tgt_row), .tgt_col(tgt_col), .allow_etch(allow_etch), .ext_mode(ext_mode),
        .status(status), .cmd(cmd), .row_sel(row_sel), .col_sel(col_sel),
        .pref_ud(pref_ud), .pref_ew(pref_ew), .pref_ns(pref_ns), .etch_enb(etch_enb),
        .extend(extend), .busy(busy), .done(done), .found(found), .fail(fail),
        .step_count(step_count)
    );

    // Array model: status registered from the command of the previous cycle.
    always @(posedge clk) begin
        if (!reset_l || done) exp_cnt <= 0;
        else if (cmd == CmdExpand) exp_cnt <= exp_cnt + 1;
        if (cmd == CmdExpand)
            status <= {2'b11, ~prog_en, !((exp_cnt / 8 + 1 == hit_step) && (exp_cnt % 8 == 5))};
        else
            status <= 4'hF;
    end

    always @(negedge clk) begin
        if (cmd == CmdClearx) begin
            clearx_total <= clearx_total + 1;
            if (!pref_ud || pref_ew || pref_ns || row_sel != 0 || col_sel != 0)
                clr_bad <= clr_bad + 1;
        end
        if (cmd == CmdExpand && (row_sel !== exp_row || col_sel !== exp_col ||
                                 !pref_ud || !pref_ew || !pref_ns))
            sel_bad <= sel_bad + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [4:0] r, input logic [4:0] c, input logic e, input logic x);
        tgt_row = r; tgt_col = c; allow_etch = e; ext_mode = x;
        exp_row = 32'd1 << r; exp_col = 32'd1 << c;
        base_clr = clearx_total; base_clr_bad = clr_bad; base_sel = sel_bad;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        while (!done && cyc < 200) tick();
        checks++;
        if (done !== 1'b1) $display("FAIL %s_done_timeout: done=%b after %0d cycles, want 1", name, done, cyc);
        else passed++;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        tick(); tick();
        checks++; if (cmd !== CmdRead || busy !== 1'b0 || done !== 1'b0) $display("FAIL por_ctrl: cmd=%0d busy=%b done=%b want 3 0 0", cmd, busy, done); else passed++;
        checks++; if ({pref_ud, pref_ew, pref_ns, etch_enb, extend} !== 5'b0 || row_sel !== 0 || col_sel !== 0) $display("FAIL por_sel: prefs=%b row=%h col=%h want 0", {pref_ud, pref_ew, pref_ns, etch_enb, extend}, row_sel, col_sel); else passed++;
        checks++; if (found !== 1'b0 || fail !== 1'b0 || step_count !== 10'd0) $display("FAIL por_result: found=%b fail=%b steps=%0d want 0 0 0", found, fail, step_count); else passed++;
        reset_l = 1'b1;
        tick();
        prog_en = 1'b1; hit_step = 0;
        launch(5'd9, 5'd3, 1'b0, 1'b0);
        while (cyc < 13) tick();
        checks++; if (cmd !== CmdExpand || step_count !== 10'd1) $display("FAIL rst_pre: cmd=%0d steps=%0d want 2 1", cmd, step_count); else passed++;
        reset_l = 1'b0;
        tick();
        checks++; if (cmd !== CmdRead || busy !== 1'b0 || step_count !== 10'd0) $display("FAIL rst_mid: cmd=%0d busy=%b steps=%0d want 3 0 0", cmd, busy, step_count); else passed++;
        checks++; if ({pref_ud, pref_ew, pref_ns} !== 3'b0 || row_sel !== 0) $display("FAIL rst_prefs: prefs=%b row=%h want 0 0", {pref_ud, pref_ew, pref_ns}, row_sel); else passed++;
        tick();
        reset_l = 1'b1;
        tick();
    endtask

    task automatic test_found();
        prog_en = 1'b1; hit_step = 3;
        launch(5'd5, 5'd31, 1'b1, 1'b1);
        checks++; if (cmd !== CmdExpand || busy !== 1'b1) $display("FAIL found_first: cmd=%0d busy=%b want 2 1", cmd, busy); else passed++;
        checks++; if (row_sel !== 32'h20 || col_sel !== 32'h8000_0000) $display("FAIL found_sel: row=%h col=%h want 00000020 80000000", row_sel, col_sel); else passed++;
        checks++; if (etch_enb !== 1'b1 || extend !== 1'b1) $display("FAIL found_ctl: etch=%b ext=%b want 1 1", etch_enb, extend); else passed++;
        wait_done("found");
        checks++; if (cyc !== 28) $display("FAIL found_latency: got %0d want 28", cyc); else passed++;
        checks++; if (found !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) $display("FAIL found_result: found=%b fail=%b busy=%b want 1 0 0", found, fail, busy); else passed++;
        checks++; if (step_count !== 10'd3) $display("FAIL found_steps: got %0d want 3", step_count); else passed++;
        checks++; if (clearx_total - base_clr !== 0 || sel_bad - base_sel !== 0) $display("FAIL found_cmds: clearx=%0d badsel=%0d want 0 0", clearx_total - base_clr, sel_bad - base_sel); else passed++;
        tick();
        checks++; if (done !== 1'b0 || found !== 1'b1 || cmd !== CmdRead) $display("FAIL found_after: done=%b found=%b cmd=%0d want 0 1 3", done, found, cmd); else passed++;
    endtask

    task automatic test_blocked();
        prog_en = 1'b0; hit_step = 0;
        launch(5'd2, 5'd7, 1'b0, 1'b0);
        wait_done("blocked");
        checks++; if (cyc !== 18) $display("FAIL blocked_latency: got %0d want 18", cyc); else passed++;
        checks++; if (fail !== 1'b1 || found !== 1'b0 || step_count !== 10'd1) $display("FAIL blocked_result: fail=%b found=%b steps=%0d want 1 0 1", fail, found, step_count); else passed++;
        checks++; if (clearx_total - base_clr !== 8 || clr_bad - base_clr_bad !== 0) $display("FAIL blocked_clear: clearx=%0d bad=%0d want 8 0", clearx_total - base_clr, clr_bad - base_clr_bad); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        prog_en = 1'b1; hit_step = 0;
        launch(5'd17, 5'd0, 1'b0, 1'b1);
        wait_done("timeout");
        checks++; if (cyc !== 45) $display("FAIL timeout_latency: got %0d want 45", cyc); else passed++;
        checks++; if (fail !== 1'b1 || found !== 1'b0 || step_count !== 10'd4) $display("FAIL timeout_result: fail=%b found=%b steps=%0d want 1 0 4", fail, found, step_count); else passed++;
        checks++; if (clearx_total - base_clr !== 8 || sel_bad - base_sel !== 0) $display("FAIL timeout_cmds: clearx=%0d badsel=%0d want 8 0", clearx_total - base_clr, sel_bad - base_sel); else passed++;
        tick();
    endtask

    task automatic test_priority();
        prog_en = 1'b1; hit_step = 4;
        launch(5'd30, 5'd12, 1'b1, 1'b0);
        wait_done("priority");
        checks++; if (cyc !== 37) $display("FAIL prio_latency: got %0d want 37", cyc); else passed++;
        checks++; if (found !== 1'b1 || fail !== 1'b0 || step_count !== 10'd4) $display("FAIL prio_result: found=%b fail=%b steps=%0d want 1 0 4", found, fail, step_count); else passed++;
        checks++; if (clearx_total - base_clr !== 0) $display("FAIL prio_clear: clearx=%0d want 0", clearx_total - base_clr); else passed++;
        tick();
    endtask

    task automatic test_abort();
        prog_en = 1'b1; hit_step = 0;
        launch(5'd0, 5'd0, 1'b0, 1'b0);
        while (cyc < 14) tick();
        checks++; if (cmd !== CmdExpand || step_count !== 10'd1) $display("FAIL abort_pre: cmd=%0d steps=%0d want 2 1", cmd, step_count); else passed++;
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        checks++; if (cmd !== CmdClearx || pref_ud !== 1'b1 || busy !== 1'b1) $display("FAIL abort_clear: cmd=%0d ud=%b busy=%b want 0 1 1", cmd, pref_ud, busy); else passed++;
        wait_done("abort");
        checks++; if (cyc !== 23) $display("FAIL abort_latency: got %0d want 23", cyc); else passed++;
        checks++; if (found !== 1'b0 || fail !== 1'b0 || step_count !== 10'd1) $display("FAIL abort_result: found=%b fail=%b steps=%0d want 0 0 1", found, fail, step_count); else passed++;
        checks++; if (clearx_total - base_clr !== 8) $display("FAIL abort_clearx: got %0d want 8", clearx_total - base_clr); else passed++;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checks++; if (cmd !== CmdRead || busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle: cmd=%0d busy=%b done=%b want 3 0 0", cmd, busy, done); else passed++;
    endtask

    initial begin
        test_reset();
        test_found();
        test_blocked();
        test_timeout();
        test_priority();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
